// File: rtl/sample_serializer_pkg.sv
// Shared definitions for the sample serializer: default widths
// and the FSM state encoding used by the block controller.
package sample_serializer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sample_serializer_piso.sv
// piso_shift: parallel-load / serial-out register, MSB first.
// Ports: clk, reset (sync, high), load, shift, din -> msb, bit_idx.
module piso_shift
  import sample_serializer_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [W-1:0]         din,
  output logic                 msb,
  output logic [$clog2(W)-1:0] bit_idx
);

  logic [W-1:0] sr;

  // A load in the bit-0 cycle overrides the shift so the next
  // word follows without a gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      bit_idx <= '0;
    end else if (load) begin
      sr      <= din;
      bit_idx <= ($clog2(W))'(W - 1);
    end else if (shift) begin
      sr      <= {sr[W-2:0], 1'b0};
      bit_idx <= bit_idx - 1'b1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/sample_serializer.sv
// Streams a block of memory words out serially, MSB first.
// Ports: Sclk, Reset, Start, Base_Address, Word_Count, Mute,
//        data_stored -> read_enable, Read_Address, Serial_Out,
//        Frame, Busy, Done.
module sample_serializer
  import sample_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Address,
  input  logic [ADDR_W:0]   Word_Count,
  input  logic              Mute,
  output logic              read_enable,
  output logic [ADDR_W-1:0] Read_Address,
  input  logic [DATA_W-1:0] data_stored,
  output logic              Serial_Out,
  output logic              Frame,
  output logic              Busy,
  output logic              Done
);

  localparam int BW = $clog2(DATA_W);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   left_q;
  logic [BW-1:0]     bit_idx;
  logic              msb;
  logic              accept;
  logic              last_bit;
  logic              more;
  logic              load;
  logic              shift;
  logic [DATA_W-1:0] load_data;

  assign accept   = (state == IDLE) && Start
                    && (Word_Count != '0);
  assign last_bit = (bit_idx == '0);
  // left_q counts words not yet loaded.
  assign more     = (left_q != '0);
  assign load_data = Mute ? '0 : data_stored;

  always_ff @(posedge Sclk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    read_enable  = 1'b0;
    Read_Address = addr_q;
    load         = 1'b0;
    shift        = 1'b0;
    Serial_Out   = 1'b0;
    Frame        = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = LOAD;
      end
      LOAD: begin
        Busy         = 1'b1;
        read_enable  = 1'b1;
        Read_Address = base_q;
        load         = 1'b1;
        state_nx     = SHIFT;
      end
      SHIFT: begin
        Busy       = 1'b1;
        shift      = 1'b1;
        Serial_Out = msb;
        Frame      = (bit_idx == BW'(DATA_W - 1));
        if (last_bit) begin
          if (more) begin
            read_enable  = 1'b1;
            Read_Address = addr_q + 1'b1;
            load         = 1'b1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // addr_q remembers the last address presented so Read_Address
  // holds between reads and the next prefetch is addr_q + 1.
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      base_q <= '0;
      addr_q <= '0;
      left_q <= '0;
    end else begin
      if (accept) begin
        base_q <= Base_Address;
        left_q <= Word_Count;
      end
      if (load) begin
        addr_q <= Read_Address;
        left_q <= left_q - 1'b1;
      end
    end
  end

  piso_shift #(
    .W(DATA_W)
  ) u_piso (
    .clk    (Sclk),
    .reset  (Reset),
    .load   (load),
    .shift  (shift),
    .din    (load_data),
    .msb    (msb),
    .bit_idx(bit_idx)
  );

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: stimulus queues expected
// reads and words, a negedge monitor pops and compares.
module tb_sample_serializer;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } wexp_t;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  Base_Address;
  logic [8:0]  Word_Count;
  logic        Mute;
  logic        read_enable;
  logic [7:0]  Read_Address;
  logic [15:0] data_stored;
  logic        Serial_Out;
  logic        Frame;
  logic        Busy;
  logic        Done;

  logic [15:0] mem [0:255];

  wexp_t       exp_words[$];
  logic [7:0]  exp_addrs[$];
  wexp_t       cur;
  int          bitpos;
  bit          pend_frame;
  bit          pend_done;
  bit          flush;
  bit          mon_en;
  int          total;
  int          bad;

  sample_serializer #(
    .DATA_W(16),
    .ADDR_W(8)
  ) dut (
    .Sclk        (clk),
    .Reset       (Reset),
    .Start       (Start),
    .Base_Address(Base_Address),
    .Word_Count  (Word_Count),
    .Mute        (Mute),
    .read_enable (read_enable),
    .Read_Address(Read_Address),
    .data_stored (data_stored),
    .Serial_Out  (Serial_Out),
    .Frame       (Frame),
    .Busy        (Busy),
    .Done        (Done)
  );

  assign data_stored = read_enable ? mem[Read_Address] : 16'hBEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (flush) begin
      exp_words.delete();
      exp_addrs.delete();
      bitpos     = -1;
      pend_frame = 1'b0;
      pend_done  = 1'b0;
      chk("rst_sout", 32'(Serial_Out), 0);
      chk("rst_frame", 32'(Frame), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_done", 32'(Done), 0);
      chk("rst_rden", 32'(read_enable), 0);
      chk("rst_raddr", 32'(Read_Address), 0);
    end else if (mon_en) begin
      if (read_enable) begin
        if (exp_addrs.size() == 0) begin
          chk("read_extra", 32'(read_enable), 0);
        end else begin
          logic [7:0] a;
          a = exp_addrs.pop_front();
          chk("read_addr", 32'(Read_Address), 32'(a));
        end
      end
      if (pend_frame) begin
        chk("gapless_frame", 32'(Frame), 1);
        pend_frame = 1'b0;
      end
      if (pend_done) begin
        chk("done_pulse", 32'(Done), 1);
        chk("done_busy", 32'(Busy), 0);
        pend_done = 1'b0;
      end else begin
        chk("done_spurious", 32'(Done), 0);
      end
      if (Frame && bitpos < 0) begin
        if (exp_words.size() == 0) begin
          chk("frame_extra", 32'(Frame), 0);
        end else begin
          cur    = exp_words.pop_front();
          bitpos = 15;
        end
      end
      if (bitpos >= 0) begin
        chk("sout", 32'(Serial_Out), 32'(cur.d[bitpos]));
        chk("frame", 32'(Frame), 32'(bitpos == 15));
        chk("busy", 32'(Busy), 1);
        if (bitpos == 0) begin
          if (cur.last) pend_done = 1'b1;
          else          pend_frame = 1'b1;
        end
        bitpos--;
      end else begin
        chk("idle_sout", 32'(Serial_Out), 0);
        chk("idle_frame", 32'(Frame), 0);
      end
    end
  end

  task automatic issue(input logic [7:0] base, input int n,
                       input int mute_from);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      wexp_t      w;
      a      = base + 8'(i);
      w.d    = (i >= mute_from) ? 16'h0000 : mem[a];
      w.last = (i == n - 1);
      exp_addrs.push_back(a);
      exp_words.push_back(w);
    end
  endtask

  task automatic go(input logic [7:0] base, input logic [8:0] cnt);
    Base_Address = base;
    Word_Count   = cnt;
    Start        = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (k < 16 * n + 40 &&
           !(exp_words.size() == 0 && exp_addrs.size() == 0 &&
             bitpos < 0 && !pend_done && !pend_frame)) begin
      @(posedge clk);
      k++;
    end
    chk("blk_words_left", 32'(exp_words.size()), 0);
    chk("blk_addrs_left", 32'(exp_addrs.size()), 0);
    exp_words.delete();
    exp_addrs.delete();
    bitpos = -1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    bitpos       = -1;
    pend_frame   = 1'b0;
    pend_done    = 1'b0;
    flush        = 1'b0;
    mon_en       = 1'b0;
    Reset        = 1'b1;
    Start        = 1'b0;
    Base_Address = 8'h00;
    Word_Count   = 9'd0;
    Mute         = 1'b0;
    for (int i = 0; i < 256; i++)
      mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
    mem[8'h10] = 16'hA5C3;
    mem[8'h20] = 16'hFFFF;
    mem[8'h21] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush  = 1'b0;
    mon_en = 1'b1;

    // Single word, latency of LOAD and first Frame.
    issue(8'h10, 1, 99);
    go(8'h10, 9'd1);
    @(negedge clk);
    chk("t1_load_rden", 32'(read_enable), 1);
    chk("t1_load_addr", 32'(Read_Address), 32'h10);
    chk("t1_load_busy", 32'(Busy), 1);
    chk("t1_load_frame", 32'(Frame), 0);
    @(negedge clk);
    chk("t1_first_frame", 32'(Frame), 1);
    wait_done(1);

    // Address wrap 0xFE, 0xFF, 0x00.
    issue(8'hFE, 3, 99);
    go(8'hFE, 9'd3);
    wait_done(3);

    // Zero word count is ignored.
    go(8'h50, 9'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_busy", 32'(Busy), 0);
      chk("zero_rden", 32'(read_enable), 0);
      chk("zero_done", 32'(Done), 0);
    end
    @(posedge clk);
    #1;

    // Mute applies only from the second load.
    issue(8'h20, 2, 1);
    go(8'h20, 9'd2);
    @(posedge clk);
    #1;
    Mute = 1'b1;
    wait_done(2);
    Mute = 1'b0;

    // Reset during bit 7 of word 1, with a Start alongside it.
    issue(8'h60, 2, 99);
    go(8'h60, 9'd2);
    repeat (9) @(posedge clk);
    #1;
    Reset        = 1'b1;
    Start        = 1'b1;
    Base_Address = 8'h70;
    Word_Count   = 9'd1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    Start = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", 32'(Busy), 0);
    @(posedge clk);
    #1;
    issue(8'h30, 1, 99);
    go(8'h30, 9'd1);
    wait_done(1);

    // Start while busy is ignored.
    issue(8'h40, 2, 99);
    go(8'h40, 9'd2);
    repeat (5) @(posedge clk);
    #1;
    go(8'h80, 9'd5);
    wait_done(2);

    // Full 256-word block from address 0.
    issue(8'h00, 256, 999);
    go(8'h00, 9'd256);
    wait_done(256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 Parameter DATA_W, default 16, sample word width.
REQ-002 Parameter ADDR_W, default 8, data-memory address width.
REQ-003 Sclk  input  1  sole clock; all state updates on posedge Sclk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to transmit a block; sampled only in IDLE.
REQ-006 Base_Address  input  ADDR_W  first memory address of the block; captured on accepted Start.
REQ-007 Word_Count  input  ADDR_W+1  number of words to send, 1..256; captured on accepted Start.
REQ-008 Mute  input  1  when high at a load, the loaded word is replaced by zero.
REQ-009 read_enable  output  1  memory read strobe.
REQ-010 Read_Address  output  ADDR_W  memory read address.
REQ-011 data_stored  input  DATA_W  memory read data; combinationally valid in the same cycle read_enable is high.
REQ-012 Serial_Out  output  1  serial data, MSB first.
REQ-013 Frame  output  1  high only during bit 15 (MSB) of each word.
REQ-014 Busy  output  1  high while a block is in progress.
REQ-015 Done  output  1  one-cycle pulse after the final bit of a block.

Function
REQ-016 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE: Start=1 and Word_Count!=0 -> LOAD next cycle; Start with Word_Count=0 is ignored.
REQ-018 Start in any state other than IDLE is ignored; captured Base_Address/Word_Count remain unchanged.
REQ-019 LOAD (one cycle): read_enable=1, Read_Address=Base_Address; shift register loads data_stored (or 0 if Mute) at cycle end; -> SHIFT.
REQ-020 SHIFT: 16 cycles per word, bit index 15 down to 0; Serial_Out=shift_reg[15] each cycle; Frame=1 in the bit-15 cycle only.
REQ-021 Gapless prefetch: in the bit-0 cycle with words remaining, read_enable=1, Read_Address=next address, shift register reloads at cycle end; next word's bit 15 follows immediately.
REQ-022 Address increment is modulo 2^ADDR_W (255 -> 0).
REQ-023 Bit-0 cycle of the last word -> DONE; DONE lasts one cycle with Done=1, Busy=0, then -> IDLE.
REQ-024 Latency: Start accepted at edge t -> LOAD in cycle t+1, first Frame in t+2; last bit in cycle t+1+16N; Done in t+2+16N.
REQ-025 Busy=1 in LOAD and SHIFT; 0 in IDLE and DONE.
REQ-026 read_enable=0 and Read_Address holds its last value except in cycles defined by REQ-019/021.
REQ-027 Serial_Out=0 and Frame=0 in IDLE, LOAD and DONE.
REQ-028 Mute is sampled per word at each load, not per block.
REQ-029 Word counter is ADDR_W+1 bits; Word_Count=256 transmits 256 words.

Reset
REQ-030 Reset=1 at a posedge forces IDLE regardless of state, including mid-word.
REQ-031 Reset values: Serial_Out=0, Frame=0, Busy=0, Done=0, read_enable=0, Read_Address=0, shift register=0, counters=0.
REQ-032 Start asserted in the same cycle as Reset is ignored.

Structure
REQ-033 Shared package holds DATA_W, ADDR_W defaults and the FSM state encoding.
REQ-034 One sub-module, piso_shift, holds the 16-bit parallel-load/serial-out register and the 4-bit bit counter; FSM and address/word counters stay in sample_serializer.

Verification
REQ-035 Base=0x10, Count=1, mem[0x10]=0xA5C3 -> Frame in 1 cycle, Serial_Out bits 1010010111000011, Done 16 cycles after Frame.
REQ-036 Base=0xFE, Count=3 -> Read_Address sequence 0xFE, 0xFF, 0x00; 48 contiguous bits; exactly 3 Frame pulses 16 cycles apart.
REQ-037 Count=0 with Start=1 -> Busy stays 0, no read_enable, no Done.
REQ-038 Mute=1 during second word of Count=2 block (mem=0xFFFF,0xFFFF) -> bits 16x1 then 16x0.
REQ-039 Reset asserted at bit 7 of word 1 -> next cycle all outputs at reset values; new Start then transmits from captured new Base_Address.
REQ-040 Start pulsed again while Busy -> ignored; block length and addresses unchanged.
